// File: rtl/game_pkg.sv
// Shared game definitions: scroll state encoding, level/world limits and the
// screen codes exchanged with the game FSM.
package game_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StScroll = 2'd1,
        StDone   = 2'd2
    } scroll_state_t;

    localparam int unsigned LEVEL_MAX = 3;
    localparam int unsigned WORLD_MAX = 6;

    // Screen codes shared with the game FSM.
    localparam logic [2:0] ScreenBlank   = 3'd0;
    localparam logic [2:0] ScreenPlay    = 3'd1;
    localparam logic [2:0] ScreenLose    = 3'd2;
    localparam logic [2:0] ScreenWin     = 3'd3;
    localparam logic [2:0] ScreenLevelUp = 3'd4;
    localparam logic [2:0] ScreenWorldUp = 3'd5;

endpackage

// File: rtl/progress_thermo.sv
// Combinational 8-step thermometer of offset against target. Bit k is set once
// offset reaches ((k+1)*target)>>3. Multiplies by the small constants are built
// from shifted copies of target so no general multiplier is inferred.
module progress_thermo #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] offset,
    input  logic [W-1:0] target,
    output logic [7:0]   thermo
);

    logic [W+3:0] t_ext;
    logic [W+3:0] o_ext;

    assign t_ext = (W+4)'(target);
    assign o_ext = (W+4)'(offset);

    for (genvar k = 0; k < 8; k++) begin : g_bit
        localparam logic [3:0] Mult = 4'(k + 1);
        logic [W+3:0] prod;

        // Shift-and-add of target by the constant k+1.
        assign prod = (Mult[0] ? t_ext        : '0) +
                      (Mult[1] ? (t_ext << 1) : '0) +
                      (Mult[2] ? (t_ext << 2) : '0) +
                      (Mult[3] ? (t_ext << 3) : '0);

        assign thermo[k] = (o_ext >= (prod >> 3));
    end

endmodule

// File: rtl/scroll_progress.sv
// Per-frame scroll offset generator. Advances at world-dependent speed toward a
// level-dependent length, then holds level_complete until the game FSM changes
// level/world or restarts.
// Optional: define SCROLL_PROGRESS_BAR_EN to add the 8-bit progress thermometer.
module scroll_progress
    import game_pkg::*;
#(
    parameter int unsigned OFFSET_W = 12,
    parameter int unsigned BASE_LEN = 1024,
    parameter int unsigned LEN_STEP = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                scroll_en,
    input  logic                restart,
    input  logic [2:0]          level,
    input  logic [2:0]          world,
    output logic                level_complete,
    output logic [OFFSET_W-1:0] scroll_offset,
    output logic [3:0]          scroll_speed,
`ifdef SCROLL_PROGRESS_BAR_EN
    output logic [7:0]          progress,
`endif
    output logic                busy
);

    // The longest level (index 7) must fit in the offset width.
    if (64'(BASE_LEN) + 64'(7) * 64'(LEN_STEP) >= (64'd1 << OFFSET_W)) begin : g_len_check
        $error("scroll_progress: BASE_LEN + 7*LEN_STEP must be < 2**OFFSET_W");
    end

    scroll_state_t       state_q, state_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [2:0]          lvl_q, lvl_d;
    logic [2:0]          wld_q, wld_d;
    logic [OFFSET_W-1:0] target;
    logic [OFFSET_W:0]   sum;
    logic                changed;

    assign target       = OFFSET_W'(BASE_LEN + LEN_STEP * 32'(lvl_q));
    assign scroll_speed = {1'b0, world} + 4'd1;
    // One bit wider than the offset so the clamp compare cannot wrap.
    assign sum          = {1'b0, offset_q} + (OFFSET_W+1)'(scroll_speed);
    assign changed      = (level != lvl_q) || (world != wld_q);

    // State, offset and latched level/world registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            offset_q <= '0;
            lvl_q    <= '0;
            wld_q    <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            lvl_q    <= lvl_d;
            wld_q    <= wld_d;
        end
    end

    // Next state: restart beats a level/world change, which beats a tick.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        lvl_d    = lvl_q;
        wld_d    = wld_q;
        if (restart) begin
            state_d  = StIdle;
            offset_d = '0;
            lvl_d    = level;
            wld_d    = world;
        end else begin
            unique case (state_q)
                StIdle: begin
                    offset_d = '0;
                    if (scroll_en) begin
                        state_d = StScroll;
                        lvl_d   = level;
                        wld_d   = world;
                    end
                end
                StScroll: begin
                    if (changed) begin
                        offset_d = '0;
                        lvl_d    = level;
                        wld_d    = world;
                    end else if (frame_tick && scroll_en) begin
                        if (sum >= {1'b0, target}) begin
                            offset_d = target;
                            state_d  = StDone;
                        end else begin
                            offset_d = sum[OFFSET_W-1:0];
                        end
                    end
                end
                StDone: begin
                    // A level/world change from the FSM is the acknowledge.
                    if (changed) begin
                        state_d  = StIdle;
                        offset_d = '0;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    offset_d = '0;
                end
            endcase
        end
    end

    // Status outputs decode directly from registered state.
    always_comb begin
        scroll_offset  = offset_q;
        level_complete = (state_q == StDone);
        busy           = (state_q == StScroll);
    end

`ifdef SCROLL_PROGRESS_BAR_EN
    logic [7:0] thermo;

    progress_thermo #(
        .W(OFFSET_W)
    ) u_thermo (
        .offset(offset_q),
        .target(target),
        .thermo(thermo)
    );

    // Progress is forced full in DONE and empty in IDLE.
    always_comb begin
        progress = thermo;
        if (state_q == StDone) begin
            progress = 8'hFF;
        end else if (state_q == StIdle) begin
            progress = 8'h00;
        end
    end
`endif

endmodule

// File: tb/tb_scroll_progress.sv
// Scoreboard bench for scroll_progress: the driver computes expected outputs
// from a behavioural model and queues them per clock edge; a monitor on the
// falling edge pops and compares.
module tb_scroll_progress;

    localparam int unsigned OW = 8;
    localparam int unsigned BL = 16;
    localparam int unsigned LS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_tick = 1'b0;
    logic          scroll_en = 1'b0;
    logic          restart = 1'b0;
    logic [2:0]    level = 3'd0;
    logic [2:0]    world = 3'd0;
    logic          level_complete;
    logic [OW-1:0] scroll_offset;
    logic [3:0]    scroll_speed;
    logic          busy;
`ifdef SCROLL_PROGRESS_BAR_EN
    logic [7:0]    progress;
`endif

    scroll_progress #(
        .OFFSET_W(OW),
        .BASE_LEN(BL),
        .LEN_STEP(LS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .scroll_en(scroll_en),
        .restart(restart),
        .level(level),
        .world(world),
        .level_complete(level_complete),
        .scroll_offset(scroll_offset),
        .scroll_speed(scroll_speed),
`ifdef SCROLL_PROGRESS_BAR_EN
        .progress(progress),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int offset;
        int lc;
        int busy;
        int prog;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    // Model: mode 0 = idle, 1 = scrolling, 2 = level complete.
    int   m_mode = 0;
    int   m_pos = 0;
    int   m_lvl = 0;
    int   m_wld = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
        end
    endfunction

    function automatic int exp_prog();
        int tgt;
        int p;
        if (m_mode == 2) return 255;
        if (m_mode == 0) return 0;
        tgt = BL + LS * m_lvl;
        p = 0;
        for (int k = 0; k < 8; k++) begin
            if (m_pos >= ((k + 1) * tgt) / 8) p = p | (1 << k);
        end
        return p;
    endfunction

    // Apply one clock's worth of input to the model.
    function automatic void model_step(input int t, input int en, input int rs,
                                       input int lv, input int wd);
        int tgt;
        if (rst == 1'b0) begin
            m_mode = 0; m_pos = 0; m_lvl = 0; m_wld = 0;
        end else if (rs != 0) begin
            m_mode = 0; m_pos = 0; m_lvl = lv; m_wld = wd;
        end else if (m_mode == 0) begin
            m_pos = 0;
            if (en != 0) begin
                m_mode = 1; m_lvl = lv; m_wld = wd;
            end
        end else if (m_mode == 1) begin
            if (lv != m_lvl || wd != m_wld) begin
                m_pos = 0; m_lvl = lv; m_wld = wd;
            end else if (t != 0 && en != 0) begin
                tgt = BL + LS * m_lvl;
                m_pos = m_pos + wd + 1;
                if (m_pos >= tgt) begin
                    m_pos  = tgt;
                    m_mode = 2;
                end
            end
        end else begin
            if (lv != m_lvl || wd != m_wld) begin
                m_mode = 0; m_pos = 0;
            end
        end
    endfunction

    task automatic step(input int t, input int en, input int rs, input int lv, input int wd);
        exp_t e;
        frame_tick = 1'(t);
        scroll_en  = 1'(en);
        restart    = 1'(rs);
        level      = 3'(lv);
        world      = 3'(wd);
        #1;
        check("scroll_speed", int'(scroll_speed), wd + 1);
        model_step(t, en, rs, lv, wd);
        e.cyc    = edge_cnt + 1;
        e.offset = m_pos;
        e.lc     = (m_mode == 2) ? 1 : 0;
        e.busy   = (m_mode == 1) ? 1 : 0;
        e.prog   = exp_prog();
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset();
        // The pending expectation predates the reset, so drop it.
        q.delete();
        rst = 1'b0;
        #1;
        check("async_offset", int'(scroll_offset), 0);
        check("async_lc", int'(level_complete), 0);
        check("async_busy", int'(busy), 0);
        m_mode = 0; m_pos = 0; m_lvl = 0; m_wld = 0;
        step(0, 0, 0, int'(level), int'(world));
        rst = 1'b1;
    endtask

    // Monitor: compare the expectation tagged with the edge just taken.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < edge_cnt) begin
            e = q.pop_front();
            check("scoreboard_missed", e.cyc, edge_cnt);
        end
        if (q.size() > 0 && q[0].cyc == edge_cnt) begin
            e = q.pop_front();
            check("scroll_offset", int'(scroll_offset), e.offset);
            check("level_complete", int'(level_complete), e.lc);
            check("busy", int'(busy), e.busy);
`ifdef SCROLL_PROGRESS_BAR_EN
            check("progress", int'(progress), e.prog);
`endif
        end
    end

    initial begin
        int lv;
        int wd;
        #2;
        // Reset held for a couple of edges.
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        rst = 1'b1;

        // Basic completion: speed 1 to length 16.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        // Acknowledge by level change, then resume toward 24.
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        // Restart mid-scroll at offset 10 (speed 2).
        step(0, 1, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 1);
        step(0, 1, 1, 1, 1);
        // Clamp: speed 3 toward 16.
        step(0, 1, 0, 0, 2);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 2);
        // Pause: length 32, speed 4.
        step(0, 1, 0, 2, 3);
        step(0, 1, 0, 2, 3);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 2, 3);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 2, 3);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 2, 3);
        step(0, 0, 0, 2, 3);
        // Asynchronous reset while complete.
        async_reset();
        // Level change coincident with the completing tick.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        // Half-way progress: length 16, offset 8.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Randomized traffic.
        lv = 0;
        wd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) lv = int'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) wd = int'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                step(int'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0) ? 1 : 0,
                     ($urandom_range(0, 149) == 0) ? 1 : 0, lv, wd);
            end
        end

        step(0, 0, 0, lv, wd);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scroll_progress.md
Name: scroll_progress

Overview:
- Producer end of the level/level_complete interface with the game FSM.
- Consumes the FSM's level/world outputs and its player-enable; advances a per-frame scroll offset at a world-dependent speed toward a level-dependent length.
- Raises level_complete and holds it until the FSM acknowledges by changing level/world or by restart.
- Drives scroll_offset to the obstacle/background renderers.

Parameters:
- OFFSET_W, 12: width of the scroll offset and level-length arithmetic.
- BASE_LEN, 1024: level length in pixels at level 0.
- LEN_STEP, 256: extra length per level index. Constraint: BASE_LEN + 7*LEN_STEP < 2^OFFSET_W. Elaboration error otherwise.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- frame_tick  in  1  one-clk pulse per video frame
- scroll_en  in  1  scrolling permitted; tied to inverse of FSM playerDisable
- restart  in  1  synchronous clear; from FSM resetSelect
- level  in  3  current level index from FSM
- world  in  3  current world index from FSM
- level_complete  out  1  level finished; level held until acknowledged
- scroll_offset  out  OFFSET_W  current scroll position in pixels
- scroll_speed  out  4  pixels advanced per frame, world+1
- busy  out  1  high while in SCROLL

Behaviour:
- Reset (rst=0, async): state IDLE, scroll_offset=0, level_complete=0, busy=0. Latched level and latched world are 0. scroll_speed is combinational from world.
- Priority each clock: restart > acknowledge/level-change > tick advance.
- restart=1 in any state: next state IDLE, offset=0, level_complete=0. Latches reload from the inputs.
- target = BASE_LEN + LEN_STEP*lvl_q, computed in OFFSET_W bits.
- speed = {1'b0,world}+1, giving a range of 1..8.
- States:
  - IDLE:
    - Offset held at 0.
    - If scroll_en=1, go to SCROLL and latch lvl_q=level and wld_q=world.
  - SCROLL:
    - busy=1.
    - On frame_tick&&scroll_en, sum = offset + speed, computed OFFSET_W+1 bits wide.
    - If sum >= target: offset <= target (clamped, never exceeds target) and go to DONE on the same edge.
    - Otherwise offset <= sum.
    - scroll_en=0 pauses: offset holds and the state is unchanged.
    - If level != lvl_q or world != wld_q mid-SCROLL: offset <= 0, relatch both, stay in SCROLL, and ignore any tick that cycle.
  - DONE:
    - level_complete=1, registered, high from the first cycle after the completing tick edge.
    - Offset holds at target. frame_tick is ignored.
    - Acknowledge is level != lvl_q or world != wld_q. On acknowledge: go to IDLE, offset <= 0, level_complete low on the next cycle.
    - scroll_en falling does not clear DONE.
- Latency: completion flag appears 1 clk after the edge where the final tick is sampled.
- level_complete is a level signal, not a pulse. The FSM's level increment is the handshake acknowledge.
- If level changes in the same cycle as the completing tick, the level change wins: offset becomes 0, relatch, and no completion.
- If frame_tick is high for consecutive clks, each high cycle counts as one tick.
- Values 0..7 on level/world are all legal, with no wrap. The parameter constraint guarantees the target fits.

Optional Feature:
- Macro: SCROLL_PROGRESS_BAR_EN.
- When defined:
  - Adds output progress[7:0], a thermometer code.
  - Bit k (0..7) is set when offset >= ((k+1)*target)>>3, using shift-and-add constant multiplies only.
  - progress is 8'hFF in DONE and 8'h00 in IDLE/reset.
  - Intended for LEDs.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package game_pkg holds:
  - scroll_state_t enum (IDLE, SCROLL, DONE);
  - LEVEL_MAX=3, WORLD_MAX=6;
  - screen code constants (BLANK, PLAY, LOSE, WIN, LEVEL_UP, WORLD_UP), shared with the FSM.
- One sub-module, progress_thermo: combinational thermometer from offset and target, instantiated only under SCROLL_PROGRESS_BAR_EN.
- Length and speed computation stays inline.

Test Plan (bench params BASE_LEN=16, LEN_STEP=8, OFFSET_W=8):
- Basic completion: level=0, world=0, scroll_en=1, 16 ticks.
  - Offset steps 1..16.
  - level_complete=1 one clk after the 16th tick edge; busy=0 afterward.
- Clamp: level=0, world=2 (speed 3), 6 ticks.
  - Offsets 3,6,9,12,15 then 16, not 18.
  - DONE after tick 6.
- Pause: level=2 (target 32), world=3 (speed 4). After 3 ticks (offset 12), drop scroll_en and send 5 ticks.
  - Offset stays 12.
  - Re-enable, then 5 more ticks reach 32 and give DONE.
- Acknowledge: in DONE, change level 0->1.
  - Next cycle: level_complete=0, offset=0, state IDLE.
  - With scroll_en=1, SCROLL resumes with target 24.
- Restart and resets:
  - Mid-SCROLL at offset 10, pulse restart: offset=0 and IDLE the next clk.
  - Separately, assert rst=0 asynchronously mid-DONE: outputs clear without a clock edge.
- Simultaneous events:
  - Level change coincident with the completing tick: no level_complete, offset=0.
  - Under SCROLL_PROGRESS_BAR_EN, target 16, offset 8: progress=8'h0F.
